datahub_xbar: RTL
=================

// Module: datahub_xbar
// PURPOSE
//  Registered, double-buffered successor to the programmable data hub: per-bit input select
//  plus per-output bit mask, routing INPUTS buses to OUTPUTS buses. Programming writes a shadow
//  config while traffic keeps flowing on the active config; PrgmCommit swaps them atomically.
//  Sits between producer/consumer buses in the research datapath; everything on PrgmClk.
// PARAMETERS
//  BUSWIDTH  8                bits per bus
//  INPUTS    4                number of input buses (>=2)
//  OUTPUTS   4                number of output buses (>=2)
//  ILOG2     $clog2(INPUTS)   input-select width (derived, do not override)
//  OLOG2     $clog2(OUTPUTS)  output-select width (derived, do not override)
// PORTS
//  PrgmClk    in   1                 clock for program, FSM and output register
//  Reset      in   1                 asynchronous, active-high reset
//  I          in   INPUTS*BUSWIDTH   input bus k = I[k*BUSWIDTH +: BUSWIDTH]
//  PrgmInSrc  in   ILOG2             input index written into shadow selects
//  PrgmOutSrc in   OLOG2             output index whose shadow mask is written
//  PrgmData   in   BUSWIDTH          bit mask (InEn) / output mask value (OutEn)
//  PrgmInEn   in   1                 write shadow input selects
//  PrgmOutEn  in   1                 write shadow output mask
//  PrgmCommit in   1                 request shadow->active swap
//  PrgmBusy   out  1                 1 in SWAP/FILL; program/commit inputs ignored
//  PrgmErr    out  1                 sticky: out-of-range program index seen
//  Invalid    out  1                 1 when O does not reflect a committed config
//  O          out  OUTPUTS*BUSWIDTH  output bus k = O[k*BUSWIDTH +: BUSWIDTH]
// BEHAVIOUR
//  Reset (async, immediate): shadow+active selects=0, masks=0, O=0, PrgmErr=0, state=UNCFG.
//  Config: sel[b] (ILOG2) per bus bit b; mask[k] (BUSWIDTH) per output k; shadow and active copies.
//  Shadow writes (edge, not busy, sampled together):
//   - PrgmInEn: for each b with PrgmData[b]=1, shadow sel[b]<=PrgmInSrc; if PrgmInSrc>=INPUTS
//     whole write dropped, PrgmErr<=1.
//   - PrgmOutEn: shadow mask[PrgmOutSrc]<=PrgmData; if PrgmOutSrc>=OUTPUTS dropped, PrgmErr<=1.
//   - Both enables same edge: both applied with same PrgmData.
//   - Shadow persists after commit (incremental reprogramming).
//  Datapath: data[b]=I[sel_act[b]*BUSWIDTH+b]; each edge O[k]<=mask_act[k] & data.
//   Latency 1 edge I->O; O updates every edge in every state except UNCFG (O held 0).
//  FSM (Invalid = state in {UNCFG,SWAP,FILL}; PrgmBusy = state in {SWAP,FILL}):
//   UNCFG: PrgmCommit -> SWAP; writes -> stay.   RUN: write -> PROG; PrgmCommit -> SWAP.
//   PROG: active unaffected, O valid from active; PrgmCommit -> SWAP.
//   SWAP (1 cycle): active<=shadow (incl. writes made on the commit edge); PrgmErr<=0; -> FILL.
//   FILL (1 cycle): O registers first value from new active; -> RUN.
//   Commit edge t: Invalid=1 after t and t+1; after t+2 O uses new config, Invalid=0.
//   Commit/writes during SWAP/FILL ignored (no error flagged). Commit with PrgmErr=1 still swaps.
//  Reset mid-SWAP/FILL: abort, all state per reset; no partial copy visible.
// TESTING
//  1 Reset, no commit, I all 0xFF, 10 edges -> O=0, Invalid=1, PrgmBusy=0, PrgmErr=0.
//  2 InSrc=2,Data=0xFF,InEn; OutSrc=1,Data=0x0F,OutEn; Commit; I2=0xA5 -> Invalid 1,1,0 over
//    3 edges; then O1=0x05, O0=O2=O3=0x00; I2->0x3C gives O1=0x0C one edge later.
//  3 From (2) write OutSrc=1,Data=0xF0, no commit -> O1 stays 0x05, Invalid=0; commit ->
//    O1=0xA0 after t+2.
//  4 INPUTS=3: InEn with InSrc=3 -> PrgmErr=1, shadow unchanged (commit shows old routing);
//    PrgmErr=0 after SWAP.
//  5 Commit, then Commit+InEn in SWAP and FILL cycles -> ignored, single swap, PrgmBusy=1 x2.
//  6 Reset pulsed during FILL -> O=0, Invalid=1 immediately, PrgmBusy=0; state UNCFG after release.

Source files
------------

// File: rtl/datahub_xbar.sv
// Double-buffered bit-level crossbar: per-bit input select plus per-output mask.
// Shadow config is programmed while the active config routes traffic; commit swaps them.
module datahub_xbar #(
   parameter  int BUSWIDTH = 8,
   parameter  int INPUTS   = 4,
   parameter  int OUTPUTS  = 4,
   localparam int ILOG2    = $clog2(INPUTS),
   localparam int OLOG2    = $clog2(OUTPUTS)
) (
   input  logic                         PrgmClk,
   input  logic                         Reset,
   input  logic [INPUTS*BUSWIDTH-1:0]   I,
   input  logic [ILOG2-1:0]             PrgmInSrc,
   input  logic [OLOG2-1:0]             PrgmOutSrc,
   input  logic [BUSWIDTH-1:0]          PrgmData,
   input  logic                         PrgmInEn,
   input  logic                         PrgmOutEn,
   input  logic                         PrgmCommit,
   output logic                         PrgmBusy,
   output logic                         PrgmErr,
   output logic                         Invalid,
   output logic [OUTPUTS*BUSWIDTH-1:0]  O
);

   typedef enum logic [2:0] {
      S_UNCFG,
      S_RUN,
      S_PROG,
      S_SWAP,
      S_FILL
   } state_t;

   state_t state_q, state_d;

   logic [BUSWIDTH-1:0][ILOG2-1:0]    sh_sel_q, sh_sel_d;
   logic [BUSWIDTH-1:0][ILOG2-1:0]    act_sel_q, act_sel_d;
   logic [OUTPUTS-1:0][BUSWIDTH-1:0]  sh_mask_q, sh_mask_d;
   logic [OUTPUTS-1:0][BUSWIDTH-1:0]  act_mask_q, act_mask_d;
   logic [OUTPUTS*BUSWIDTH-1:0]       o_q, o_d;
   logic                              err_q, err_d;

   logic                busy;
   logic                wr;
   logic                in_bad;
   logic                out_bad;
   logic [BUSWIDTH-1:0] data;

   assign busy    = (state_q == S_SWAP) || (state_q == S_FILL);
   assign wr      = PrgmInEn || PrgmOutEn;
   assign in_bad  = 32'(PrgmInSrc) >= 32'(INPUTS);
   assign out_bad = 32'(PrgmOutSrc) >= 32'(OUTPUTS);

   always_comb begin
      state_d    = state_q;
      sh_sel_d   = sh_sel_q;
      act_sel_d  = act_sel_q;
      sh_mask_d  = sh_mask_q;
      act_mask_d = act_mask_q;
      err_d      = err_q;
      o_d        = '0;
      data       = '0;

      if (!busy) begin
         if (PrgmInEn) begin
            if (in_bad) begin
               err_d = 1'b1;
            end else begin
               for (int b = 0; b < BUSWIDTH; b++) begin
                  if (PrgmData[b]) sh_sel_d[b] = PrgmInSrc;
               end
            end
         end
         if (PrgmOutEn) begin
            if (out_bad) err_d = 1'b1;
            else         sh_mask_d[PrgmOutSrc] = PrgmData;
         end
      end

      // A select can only ever hold an in-range index, so no fallback path is needed.
      for (int b = 0; b < BUSWIDTH; b++) begin
         for (int k = 0; k < INPUTS; k++) begin
            if (act_sel_q[b] == ILOG2'(k)) data[b] = I[k*BUSWIDTH+b];
         end
      end

      if (state_q != S_UNCFG) begin
         for (int k = 0; k < OUTPUTS; k++) begin
            o_d[k*BUSWIDTH +: BUSWIDTH] = act_mask_q[k] & data;
         end
      end

      case (state_q)
         S_UNCFG: begin
            if (PrgmCommit) state_d = S_SWAP;
         end
         S_RUN: begin
            if (PrgmCommit) state_d = S_SWAP;
            else if (wr)    state_d = S_PROG;
         end
         S_PROG: begin
            if (PrgmCommit) state_d = S_SWAP;
         end
         S_SWAP: begin
            act_sel_d  = sh_sel_q;
            act_mask_d = sh_mask_q;
            err_d      = 1'b0;
            state_d    = S_FILL;
         end
         S_FILL: begin
            state_d = S_RUN;
         end
         default: begin
            state_d = S_UNCFG;
         end
      endcase
   end

   always_ff @(posedge PrgmClk or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_UNCFG;
         sh_sel_q   <= '0;
         act_sel_q  <= '0;
         sh_mask_q  <= '0;
         act_mask_q <= '0;
         o_q        <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_sel_q   <= sh_sel_d;
         act_sel_q  <= act_sel_d;
         sh_mask_q  <= sh_mask_d;
         act_mask_q <= act_mask_d;
         o_q        <= o_d;
         err_q      <= err_d;
      end
   end

   assign PrgmBusy = busy;
   assign Invalid  = (state_q == S_UNCFG) || busy;
   assign PrgmErr  = err_q;
   assign O        = o_q;

endmodule
